// File: rtl/qam16_pkg.sv
// Shared 16-QAM definitions for the mapper, demapper and nibble packer.
// Provides the symbol width, the symbol type and the per-axis Gray codes.
package qam16_pkg;

    localparam int QAM16_SYM_W = 4;

    typedef logic [QAM16_SYM_W-1:0] sym4_t;

    // Per-axis 2-bit Gray codes, ordered by amplitude level -3, -1, +1, +3.
    localparam logic [1:0] QAM16_GRAY_M3 = 2'b00;
    localparam logic [1:0] QAM16_GRAY_M1 = 2'b01;
    localparam logic [1:0] QAM16_GRAY_P1 = 2'b11;
    localparam logic [1:0] QAM16_GRAY_P3 = 2'b10;

endpackage

// File: rtl/qam16_word_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Ports: clk_i, rst_i (sync, high), push_i/data_i, pop_i/data_o,
// full_o, empty_o, fill_o. A push while full is accepted only when a
// pop happens in the same cycle. data_o reads 0 while empty.
module qam16_word_fifo
    import qam16_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   fill_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [FW-1:0] fill_q, fill_d;
    logic          do_push, do_pop;

    assign empty_o = (fill_q == '0);
    assign full_o  = (fill_q == FW'(DEPTH));
    assign fill_o  = fill_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        fill_d = fill_q;
        if (do_push && !do_pop) begin
            fill_d = fill_q + 1'b1;
        end else if (do_pop && !do_push) begin
            fill_d = fill_q - 1'b1;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/qam16_nibble_packer.sv
// Packs demapped 16-QAM symbols (MSB nibble first) into OUT_W-bit words,
// buffers them in a word FIFO and streams them out over valid/ready.
// Ports: clk, rst (sync, high), sym_valid/sym from the demapper, flush
// (emit partial word, zero-padded), m_data/m_valid/m_ready output stream,
// overflow (sticky word drop), fill (FIFO occupancy).
// Define QAM16_PACKER_PARITY_EN to add m_parity (even parity of m_data).
module qam16_nibble_packer
    import qam16_pkg::*;
#(
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sym_valid,
    input  sym4_t                         sym,
    input  logic                          flush,
    output logic [OUT_W-1:0]              m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          overflow,
`ifdef QAM16_PACKER_PARITY_EN
    output logic                          m_parity,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fill
);

    localparam int N  = OUT_W / QAM16_SYM_W;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef QAM16_PACKER_PARITY_EN
    localparam int FIFO_W = OUT_W + 1;
`else
    localparam int FIFO_W = OUT_W;
`endif

    logic [OUT_W-1:0]  asm_q, asm_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [OUT_W-1:0]  word_w;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_W-1:0] fifo_din;
    logic [FIFO_W-1:0] fifo_dout;

    // Current assembly with the incoming symbol dropped into slot cnt.
    always_comb begin
        word_w = asm_q;
        if (sym_valid) begin
            for (int i = 0; i < N; i++) begin
                if (CW'(i) == cnt_q) begin
                    word_w[OUT_W-1-4*i -: 4] = sym;
                end
            end
        end
    end

    // Assembly is cleared on every push so unfilled slots of a flushed
    // word are already zero.
    always_comb begin
        asm_d = asm_q;
        cnt_d = cnt_q;
        push  = 1'b0;
        if (sym_valid) begin
            if (cnt_q == LAST || flush) begin
                push  = 1'b1;
                asm_d = '0;
                cnt_d = '0;
            end else begin
                asm_d = word_w;
                cnt_d = cnt_q + 1'b1;
            end
        end else if (flush && cnt_q != '0) begin
            push  = 1'b1;
            asm_d = '0;
            cnt_d = '0;
        end
    end

    assign pop   = m_valid && m_ready;
    assign ovf_d = ovf_q || (push && fifo_full && !pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            asm_q <= asm_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef QAM16_PACKER_PARITY_EN
    assign fifo_din = {^word_w, word_w};
    assign m_parity = fifo_dout[OUT_W];
`else
    assign fifo_din = word_w;
`endif

    qam16_word_fifo #(
        .W     (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .data_i  (fifo_din),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .fill_o  (fill)
    );

    assign m_data   = fifo_dout[OUT_W-1:0];
    assign m_valid  = !fifo_empty;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_qam16_nibble_packer.sv
// Randomised scoreboard bench for qam16_nibble_packer (OUT_W=8, depth 4).
// A word-level reference model predicts accepted words, fill and overflow.
module tb_qam16_nibble_packer;

    localparam int OUT_W = 8;
    localparam int DEPTH = 4;
    localparam int N     = OUT_W / 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     sym_valid = 1'b0;
    logic [3:0]               sym = '0;
    logic                     flush = 1'b0;
    logic [OUT_W-1:0]         m_data;
    logic                     m_valid;
    logic                     m_ready = 1'b0;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   fill;
`ifdef QAM16_PACKER_PARITY_EN
    logic                     m_parity;
`endif

    qam16_nibble_packer #(
        .OUT_W      (OUT_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_valid (sym_valid),
        .sym       (sym),
        .flush     (flush),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .overflow  (overflow),
`ifdef QAM16_PACKER_PARITY_EN
        .m_parity  (m_parity),
`endif
        .fill      (fill)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [OUT_W-1:0] exp_q [$];
    logic [3:0]       mnibs [$];
    int               mcount = 0;
    bit               movf   = 1'b0;
    bit               after_rst = 1'b0;

    // Expectations for the cycle currently being presented.
    int chk_fill = 0;
    bit chk_ovf  = 1'b0;
    bit chk_rst  = 1'b0;
    bit mon_en   = 1'b0;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp,
                     $time);
        end
    endfunction

    function automatic logic [OUT_W-1:0] build_word();
        logic [OUT_W-1:0] w = '0;
        for (int i = 0; i < mnibs.size(); i++) begin
            w = w | (OUT_W'(mnibs[i]) << (4 * (N - 1 - i)));
        end
        return w;
    endfunction

    task automatic step(bit sv, logic [3:0] s, bit fl, bit rdy, bit r);
        bit pop;
        logic [OUT_W-1:0] w;
        @(posedge clk);
        #1;
        sym_valid = sv;
        sym       = s;
        flush     = fl;
        m_ready   = r ? 1'b0 : rdy;
        rst       = r;
        chk_fill  = mcount;
        chk_ovf   = movf;
        chk_rst   = after_rst;
        after_rst = r;
        if (r) begin
            mcount = 0;
            movf   = 1'b0;
            mnibs.delete();
            exp_q.delete();
        end else begin
            pop = rdy && (mcount > 0);
            if (sv) mnibs.push_back(s);
            if (mnibs.size() == N || (fl && mnibs.size() > 0)) begin
                w = build_word();
                mnibs.delete();
                if (mcount < DEPTH || pop) begin
                    exp_q.push_back(w);
                    mcount++;
                end else begin
                    movf = 1'b1;
                end
            end
            if (pop) mcount--;
        end
    endtask

    // Monitor: compares presented state and pops the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            check("fill", 32'(fill), 32'(chk_fill));
            check("m_valid", 32'(m_valid), 32'(chk_fill != 0));
            check("overflow", 32'(overflow), 32'(chk_ovf));
            if (chk_rst) begin
                check("rst_m_data", 32'(m_data), 32'h0);
`ifdef QAM16_PACKER_PARITY_EN
                check("rst_m_parity", 32'(m_parity), 32'h0);
`endif
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
`ifdef QAM16_PACKER_PARITY_EN
                    check("m_parity", 32'(m_parity), 32'(^m_data));
`endif
                end
            end
        end
    end

    initial begin
        bit sv, fl, rdy, r;
        // Initial reset: DUT resets on the first edge.
        @(posedge clk);
        #1;
        rst       = 1'b0;
        chk_fill  = 0;
        chk_ovf   = 1'b0;
        after_rst = 1'b1;
        mon_en    = 1'b1;

        // Two symbols form 0xA3, popped after it appears.
        step(1, 4'hA, 0, 0, 0);
        step(1, 4'h3, 0, 0, 0);
        step(0, 4'h0, 0, 0, 0);
        step(0, 4'h0, 0, 1, 0);
        step(0, 4'h0, 0, 0, 0);

        // Continuous 0..7 with ready high.
        for (int i = 0; i < 8; i++) step(1, 4'(i), 0, 1, 0);
        step(0, 4'h0, 0, 1, 0);
        step(0, 4'h0, 0, 1, 0);

        // Partial flush, then idle flush.
        step(1, 4'hC, 0, 0, 0);
        step(0, 4'h0, 1, 0, 0);
        step(0, 4'h0, 1, 0, 0);
        step(0, 4'h0, 0, 1, 0);
        step(0, 4'h0, 0, 0, 0);

        // Fill to 4, drop the fifth word, then drain.
        for (int i = 0; i < 10; i++) step(1, 4'(i), 0, 0, 0);
        step(0, 4'h0, 0, 0, 0);
        step(1, 4'hE, 0, 0, 0);
        step(1, 4'hF, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 4'h0, 0, 1, 0);

        // Flush coincident with a completing symbol.
        step(1, 4'h1, 0, 0, 0);
        step(1, 4'h2, 1, 0, 0);
        step(1, 4'h3, 1, 1, 0);
        step(0, 4'h0, 0, 1, 0);
        step(0, 4'h0, 0, 1, 0);

        // Reset mid-word discards the pending nibble.
        step(1, 4'h9, 0, 0, 0);
        step(0, 4'h0, 0, 0, 1);
        step(1, 4'h5, 0, 0, 0);
        step(1, 4'h6, 0, 0, 0);
        step(1, 4'h5, 0, 1, 0);
        step(1, 4'h7, 0, 1, 0);
        step(0, 4'h0, 0, 1, 0);
        step(0, 4'h0, 0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            sv  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 2) != 0) ^ (i[9] == 1'b1);
            r   = ($urandom_range(0, 299) == 0);
            step(sv, 4'($urandom_range(0, 15)), fl, rdy, r);
        end

        // Drain with a bounded budget.
        for (int i = 0; i < DEPTH + 4; i++) step(0, 4'h0, 0, 1, 0);
        @(negedge clk);
        #1;
        check("drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qam16_nibble_packer.md
Name: qam16_nibble_packer

Overview:
- Sits directly downstream of the 16-QAM demapper.
- Consumes one 4-bit Gray-decoded symbol per cycle on which the demapper's ready strobe (rdout) is high.
- Packs consecutive symbols into OUT_W-bit words and buffers them in a small FIFO.
- Presents words on a valid/ready stream to the byte sink (DMA/AXI-Stream bridge); partial words are emitted on flush, and lost words are flagged.

Parameters:
- OUT_W, 8, output word width; multiple of 4, range 8..32; N = OUT_W/4 symbols per word.
- FIFO_DEPTH, 4, word FIFO depth; power of two, range 2..16.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- sym_valid  in  1  symbol strobe; wired to demapper rdout; every high cycle is one symbol.
- sym  in  4  demapped symbol; wired to demapper dout.
- flush  in  1  single-cycle request to emit the pending partial word.
- m_data  out  OUT_W  packed word at FIFO head.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  sink accepts m_data when m_valid && m_ready.
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
- fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at an edge):
  - m_valid=0, m_data=0, overflow=0, fill=0.
  - Assembly register and nibble counter cleared; FIFO emptied.
  - A reset mid-word discards the partial word; rst overrides all other inputs.
- Packing order: first symbol of a word lands in m_data[OUT_W-1 -: 4] (MSB nibble); the last symbol lands in bits [3:0].
- Nibble counter cnt runs 0..N-1. This is the only state and the implicit FSM: EMPTY (cnt=0) / FILLING (cnt>0).
- sym_valid with cnt<N-1: store nibble at slot cnt, cnt++.
- sym_valid with cnt=N-1: the completed word (including this nibble) is pushed the same edge; cnt returns to 0.
- Latency: m_valid rises on the edge after the completing symbol's edge when the FIFO was empty. FIFO is first-word fall-through.
- flush with cnt>0 and no sym_valid: push the assembly register with unfilled slots zero, cnt←0.
- flush with cnt=0: no push, no effect.
- flush together with sym_valid: the symbol is packed first, then the word (zero-padded if still partial) is pushed; cnt←0. If that symbol completes the word, exactly one word is pushed.
- Pop: on m_valid && m_ready, head advances on that edge.
- Push while full:
  - If a pop occurs the same cycle, the push is accepted and fill is unchanged.
  - Otherwise the word is dropped and overflow←1, sticky until rst.
- Push and pop when fill=0: the word is written and m_valid rises next cycle; there is no bypass in the same cycle.
- Pointers wrap modulo FIFO_DEPTH; full/empty are derived from fill.
- m_data is held stable while m_valid && !m_ready.
- Symbol input has no backpressure; the demapper cannot stall.

Optional Feature:
- Macro: QAM16_PACKER_PARITY_EN.
- Defined:
  - Extra output port m_parity (1 bit) = XOR of all bits of m_data (even parity), stored in the FIFO alongside each word.
  - m_parity is 0 at reset.
- Undefined: the port does not exist; FIFO width is OUT_W.

Decomposition:
- Shared package qam16_pkg:
  - QAM16_SYM_W=4.
  - Symbol typedef sym4_t.
  - Gray codeword constants shared with the mapper/demapper.
- Sub-module qam16_word_fifo:
  - Parameterised width/depth synchronous FWFT FIFO.
  - Ports: push/pop/full/empty/fill.
  - The packer instantiates one.

Test Plan:
- OUT_W=8, rst released, sym_valid for 2 cycles with sym=4'hA, 4'h3 → one cycle later m_valid=1, m_data=8'hA3, fill=1; m_ready=1 pops, m_valid=0 next cycle.
- Continuous sym_valid, 8 symbols 0..7, m_ready=1 → words 8'h01, 8'h23, 8'h45, 8'h67 in order, no overflow.
- One symbol 4'hC then flush → m_data=8'hC0. flush asserted with cnt=0 → no word, fill unchanged.
- m_ready=0, 10 symbols with FIFO_DEPTH=4 → fill=4; the fifth word is dropped and overflow=1; m_data stays 8'h01 until popped; overflow stays 1 after draining.
- Full FIFO, completing symbol coincident with m_ready=1 → fill stays 4, no overflow, the new word appears last.
- rst pulsed after one symbol (cnt=1), then symbols 4'h5, 4'h6 → m_data=8'h56; the pre-reset nibble is absent. With QAM16_PACKER_PARITY_EN: 8'h56 → m_parity=0, 8'h57 → 1.
